// File: rtl/bp_be_ptw_ctrl.sv
// ============================================================================
// bp_be_ptw_ctrl
// ----------------------------------------------------------------------------
// Sv39 page-table-walk sequencer. It accepts one I/D-TLB miss at a time and
// reads PTEs level by level, checking each one. Every walk ends with either a
// single TLB-fill pulse or a single page-fault pulse. busy_o back-pressures
// further misses while a walk is in flight.
//
// Optional feature macro: BP_PTW_SUPERPAGE_EN
//   defined   : leaves above level 0 are legal when their low PPN bits are
//               zero. The VPN bits below the leaf level are merged into the
//               tag, and fill_lvl_o reports the leaf level.
//   undefined : any leaf above level 0 faults, and fill_lvl_o is always 0.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   flush_i                 abort the current walk (the walk drains if a
//                           read is outstanding)
//   satp_ppn_i              root table PPN, sampled when a miss is accepted
//   *_miss_v_i, miss_vaddr_i  miss requests (instr > store > load)
//   busy_o                  walk in progress
//   mem_req_*               PTE read request (valid/ready)
//   mem_resp_*              PTE read response (one per accepted request)
//   fill_*                  1-cycle TLB fill pulse and payload
//   *_page_fault_v_o        1-cycle fault pulses
//   fault_vaddr_o           vaddr of the faulting access
// ============================================================================
module bp_be_ptw_ctrl #(
    parameter int vaddr_width_p = 39,
    parameter int paddr_width_p = 40,
    parameter int ptag_width_p  = 28,
    parameter int pt_depth_p    = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic [ptag_width_p-1:0]  satp_ppn_i,
    input  logic                     instr_miss_v_i,
    input  logic                     load_miss_v_i,
    input  logic                     store_miss_v_i,
    input  logic [vaddr_width_p-1:0] miss_vaddr_i,
    output logic                     busy_o,
    output logic                     mem_req_v_o,
    output logic [paddr_width_p-1:0] mem_req_paddr_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_resp_v_i,
    input  logic [63:0]              mem_resp_data_i,
    output logic                     fill_v_o,
    output logic                     fill_itlb_o,
    output logic [vaddr_width_p-1:0] fill_vaddr_o,
    output logic [ptag_width_p-1:0]  fill_ptag_o,
    output logic [6:0]               fill_flags_o,
    output logic [1:0]               fill_lvl_o,
    output logic                     instr_page_fault_v_o,
    output logic                     load_page_fault_v_o,
    output logic                     store_page_fault_v_o,
    output logic [vaddr_width_p-1:0] fault_vaddr_o
);

    localparam int lvl_width_lp = $clog2(pt_depth_p);
    localparam int addr_full_lp = ptag_width_p + 9 + 3;

    typedef enum logic [2:0] {
        e_idle, e_send, e_wait, e_done, e_fault, e_drain
    } state_e;

    typedef enum logic [1:0] {
        e_miss_instr, e_miss_load, e_miss_store
    } miss_e;

    state_e                   r_state;
    miss_e                    r_type;
    logic [lvl_width_lp-1:0]  r_lvl;
    logic [ptag_width_p-1:0]  r_ppn;
    logic [vaddr_width_p-1:0] r_vaddr;
    logic                     r_busy;
    logic                     r_req_v;
    logic                     r_fill_v;
    logic                     r_fill_itlb;
    logic [ptag_width_p-1:0]  r_fill_ptag;
    logic [6:0]               r_fill_flags;
    logic [lvl_width_lp-1:0]  r_fill_lvl;
    logic                     r_instr_pf;
    logic                     r_load_pf;
    logic                     r_store_pf;

    // ------------------------------------------------------------------
    // PTE decode
    // ------------------------------------------------------------------
    logic                    w_pte_v, w_pte_r, w_pte_w, w_pte_x, w_pte_a, w_pte_d;
    logic [43:0]             w_pte_ppn_full;
    logic [ptag_width_p-1:0] w_pte_ppn;
    logic                    w_ppn_overflow;
    logic                    w_pte_invalid;
    logic                    w_pte_leaf;
    logic                    w_leaf_fault;
    logic                    w_walk_fault;
    logic                    w_sp_fault;
    logic [ptag_width_p-1:0] w_leaf_ptag;
    logic [lvl_width_lp-1:0] w_leaf_lvl;
    logic                    w_any_miss;
    logic [8:0]              w_vpn;
    logic [addr_full_lp-1:0] w_pte_addr_full;
    logic                    w_unused_pte_bits;

    assign w_pte_v        = mem_resp_data_i[0];
    assign w_pte_r        = mem_resp_data_i[1];
    assign w_pte_w        = mem_resp_data_i[2];
    assign w_pte_x        = mem_resp_data_i[3];
    assign w_pte_a        = mem_resp_data_i[6];
    assign w_pte_d        = mem_resp_data_i[7];
    assign w_pte_ppn_full = mem_resp_data_i[53:10];
    assign w_pte_ppn      = w_pte_ppn_full[ptag_width_p-1:0];
    // Reserved/RSW bits and U/G (which only travel through fill_flags_o) are not interpreted.
    assign w_unused_pte_bits = ^{mem_resp_data_i[63:54], mem_resp_data_i[9:8]};

    // PPN bits beyond the physical tag cannot be represented: treat as a bad PTE.
    assign w_ppn_overflow = |w_pte_ppn_full[43:ptag_width_p];
    assign w_pte_invalid  = ~w_pte_v | (~w_pte_r & w_pte_w) | w_ppn_overflow;
    assign w_pte_leaf     = w_pte_r | w_pte_x;

`ifdef BP_PTW_SUPERPAGE_EN
    logic [ptag_width_p-1:0] w_sp_mask;

    // NOTE: every signal driven in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_sp_mask = '0;
        case (r_lvl)
            2'd0:    w_sp_mask = '0;
            2'd1:    w_sp_mask = ptag_width_p'(28'h00001FF);
            default: w_sp_mask = ptag_width_p'(28'h003FFFF);
        endcase
    end

    // A superpage PPN must be aligned to its size; the vaddr supplies the low VPN bits.
    assign w_sp_fault  = |(w_pte_ppn & w_sp_mask);
    assign w_leaf_ptag = (w_pte_ppn & ~w_sp_mask)
                       | (ptag_width_p'(r_vaddr[vaddr_width_p-1:12]) & w_sp_mask);
    assign w_leaf_lvl  = r_lvl;
`else
    assign w_sp_fault  = (r_lvl != '0);
    assign w_leaf_ptag = w_pte_ppn;
    assign w_leaf_lvl  = '0;
`endif

    assign w_leaf_fault = ((r_type == e_miss_instr) & ~w_pte_x)
                        | ((r_type == e_miss_load)  & ~w_pte_r)
                        | ((r_type == e_miss_store) & ~w_pte_w)
                        | ~w_pte_a
                        | ((r_type == e_miss_store) & ~w_pte_d)
                        | w_sp_fault;

    assign w_walk_fault = w_pte_invalid
                        | (~w_pte_leaf & (r_lvl == '0))
                        | (w_pte_leaf & w_leaf_fault);

    assign w_any_miss = instr_miss_v_i | load_miss_v_i | store_miss_v_i;

    // VPN slice indexed by the current level.
    always_comb begin
        w_vpn = r_vaddr[38:30];
        case (r_lvl)
            2'd0:    w_vpn = r_vaddr[20:12];
            2'd1:    w_vpn = r_vaddr[29:21];
            default: w_vpn = r_vaddr[38:30];
        endcase
    end

    // The PTE address is built from registers only, so it stays stable while the request waits.
    assign w_pte_addr_full = {r_ppn, w_vpn, 3'b000};
    assign mem_req_paddr_o = w_pte_addr_full[paddr_width_p-1:0];

    // ------------------------------------------------------------------
    // Walk FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: the reset is synchronous, and all state updates use non-blocking assignments, so every
    //       register samples the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= e_idle;
            r_type       <= e_miss_load;
            r_lvl        <= '0;
            r_ppn        <= '0;
            r_vaddr      <= '0;
            r_busy       <= 1'b0;
            r_req_v      <= 1'b0;
            r_fill_v     <= 1'b0;
            r_fill_itlb  <= 1'b0;
            r_fill_ptag  <= '0;
            r_fill_flags <= '0;
            r_fill_lvl   <= '0;
            r_instr_pf   <= 1'b0;
            r_load_pf    <= 1'b0;
            r_store_pf   <= 1'b0;
        end else begin
            r_fill_v   <= 1'b0;
            r_instr_pf <= 1'b0;
            r_load_pf  <= 1'b0;
            r_store_pf <= 1'b0;

            case (r_state)
                e_idle: begin
                    // A flush in the same cycle wins over a miss.
                    if (!flush_i && w_any_miss) begin
                        r_state <= e_send;
                        r_busy  <= 1'b1;
                        r_req_v <= 1'b1;
                        r_vaddr <= miss_vaddr_i;
                        r_ppn   <= satp_ppn_i;
                        r_lvl   <= lvl_width_lp'(pt_depth_p - 1);
                        if (instr_miss_v_i)      r_type <= e_miss_instr;
                        else if (store_miss_v_i) r_type <= e_miss_store;
                        else                     r_type <= e_miss_load;
                    end
                end

                e_send: begin
                    if (mem_req_ready_i) begin
                        r_req_v <= 1'b0;
                        // A request accepted in the flush cycle still returns data: drain it.
                        r_state <= flush_i ? e_drain : e_wait;
                    end else if (flush_i) begin
                        r_req_v <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= e_idle;
                    end
                end

                e_wait: begin
                    if (flush_i) begin
                        if (mem_resp_v_i) begin
                            r_busy  <= 1'b0;
                            r_state <= e_idle;
                        end else begin
                            r_state <= e_drain;
                        end
                    end else if (mem_resp_v_i) begin
                        if (w_walk_fault) begin
                            r_state    <= e_fault;
                            r_instr_pf <= (r_type == e_miss_instr);
                            r_load_pf  <= (r_type == e_miss_load);
                            r_store_pf <= (r_type == e_miss_store);
                        end else if (!w_pte_leaf) begin
                            r_ppn   <= w_pte_ppn;
                            r_lvl   <= r_lvl - lvl_width_lp'(1);
                            r_req_v <= 1'b1;
                            r_state <= e_send;
                        end else begin
                            r_state      <= e_done;
                            r_fill_v     <= 1'b1;
                            r_fill_itlb  <= (r_type == e_miss_instr);
                            r_fill_ptag  <= w_leaf_ptag;
                            r_fill_flags <= mem_resp_data_i[7:1];
                            r_fill_lvl   <= w_leaf_lvl;
                        end
                    end
                end

                e_done, e_fault: begin
                    r_busy  <= 1'b0;
                    r_state <= e_idle;
                end

                e_drain: begin
                    if (mem_resp_v_i) begin
                        r_busy  <= 1'b0;
                        r_state <= e_idle;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_req_v <= 1'b0;
                    r_state <= e_idle;
                end
            endcase
        end
    end

    assign busy_o               = r_busy;
    assign mem_req_v_o          = r_req_v;
    assign fill_v_o             = r_fill_v;
    assign fill_itlb_o          = r_fill_itlb;
    assign fill_vaddr_o         = r_vaddr;
    assign fill_ptag_o          = r_fill_ptag;
    assign fill_flags_o         = r_fill_flags;
    assign fill_lvl_o           = 2'(r_fill_lvl);
    assign instr_page_fault_v_o = r_instr_pf;
    assign load_page_fault_v_o  = r_load_pf;
    assign store_page_fault_v_o = r_store_pf;
    assign fault_vaddr_o        = r_vaddr;

    // Misses that arrive while a walk is in flight are dropped. Flag them in simulation.
    a_no_miss_while_busy: assert property (@(posedge clk_i) disable iff (reset_i)
        busy_o |-> !w_any_miss)
        else $error("bp_be_ptw_ctrl: miss dropped while busy");

endmodule
